uart_tx_cfg: RTL

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 56 +++++
 rtl/uart_tx_cfg.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM state
// encoding, parity-mode constants and the baud divisor helper.
package uart_pkg;

    // Transmit FSM states, in the order a frame passes through them
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Parity modes selected by the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per bit time, rounded down
    function automatic int baud_div(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock show-ahead FIFO used as the transmit word buffer.
// pop_data always presents the oldest entry; a push is taken while full
// as long as a pop happens in the same cycle, so the count stays put.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries below count are ever read out
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (start, DATA_BITS LSB first, optional
// parity, STOP_BITS stop bits). Define UART_TX_FIFO_EN to buffer words in
// a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int DIV      = baud_div(CLOCK_FREQ, BAUD_RATE);
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CW       = $clog2(STOP_LEN + 1);
    localparam int IW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_LEN - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    tx_state_t            state, state_n;
    logic [CW-1:0]        baud_cnt, baud_cnt_n;
    logic [IW-1:0]        bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift_reg, shift_reg_n;
    logic                 parity_bit, parity_bit_n;

    logic                 word_avail;
    logic [DATA_BITS-1:0] word_data;
    logic                 word_pop;
    logic                 word_parity;

    assign tx_busy     = (state != ST_IDLE);
    assign word_parity = (PARITY == PAR_ODD) ? ~^word_data : ^word_data;

`ifdef UART_TX_FIFO_EN
    logic fifo_empty;
    logic fifo_full;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (word_pop),
        .pop_data  (word_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign word_avail = !fifo_empty;
    assign in_ready   = !fifo_full || word_pop;
`else
    logic                 hold_valid;
    logic [DATA_BITS-1:0] hold_data;
    logic [31:0]          unused_fifo_depth;

    // FIFO_DEPTH has no meaning with a single holding register
    assign unused_fifo_depth = FIFO_DEPTH;
    assign word_avail        = hold_valid;
    assign word_data         = hold_data;
    assign in_ready          = !tx_busy && !hold_valid;

    // Holding register fills on handshake and empties when the FSM takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (in_valid && in_ready) begin
            hold_valid <= 1'b1;
            hold_data  <= in_data;
        end else if (word_pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // FSM state, bit timer and frame registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_idx    <= bit_idx_n;
            shift_reg  <= shift_reg_n;
            parity_bit <= parity_bit_n;
        end
    end

    // Next-state, line level and word fetch; the timer restarts at every
    // bit boundary so each frame starts with a clean, full start bit
    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_cnt + 1'b1;
        bit_idx_n    = bit_idx;
        shift_reg_n  = shift_reg;
        parity_bit_n = parity_bit;
        word_pop     = 1'b0;
        tx_done      = 1'b0;
        tx_serial    = 1'b1;

        case (state)
            ST_IDLE: begin
                baud_cnt_n = '0;
                if (word_avail) begin
                    word_pop     = 1'b1;
                    shift_reg_n  = word_data;
                    parity_bit_n = word_parity;
                    state_n      = ST_START;
                end
            end
            ST_START: begin
                tx_serial = 1'b0;
                if (baud_cnt == BIT_END) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_serial = shift_reg[0];
                if (baud_cnt == BIT_END) begin
                    baud_cnt_n  = '0;
                    shift_reg_n = shift_reg >> 1;
                    if (bit_idx == LAST_BIT) begin
                        state_n = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                tx_serial = parity_bit;
                if (baud_cnt == BIT_END) begin
                    baud_cnt_n = '0;
                    state_n    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_cnt == STOP_END) begin
                    tx_done    = 1'b1;
                    baud_cnt_n = '0;
                    if (word_avail) begin
                        word_pop     = 1'b1;
                        shift_reg_n  = word_data;
                        parity_bit_n = word_parity;
                        state_n      = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n    = ST_IDLE;
                baud_cnt_n = '0;
            end
        endcase
    end

endmodule
